// File: rtl/multicycle_exec_unit.sv
// -----------------------------------------------------------------------------
// multicycle_exec_unit
//
// EX-stage execution unit: single-cycle ALU and barrel shifter, plus an
// iterative signed/unsigned multiplier (radix-2 shift-add) and restoring
// divider that write a HI/LO register pair after WIDTH iterations.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low; clears all state
//   ALUOp    in   00 ADD, 01 SUB, 10 decode funct, 11 SLT
//   funct    in   R-type function code
//   start    in   instruction valid in EX this cycle
//   dataA    in   rs operand
//   dataB    in   rt operand
//   shamt    in   shift amount
//   Output   out  selected result (combinational)
//   zero     out  ALU result equals 0 (combinational)
//   busy     out  multiply/divide in progress
//   done     out  one-cycle pulse, HI/LO just updated
//   stall    out  EX must hold the current instruction
// -----------------------------------------------------------------------------
module multicycle_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       funct,
   input  logic             start,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] Output,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [5:0] F_SLL   = 6'd0;
   localparam logic [5:0] F_SRL   = 6'd2;
   localparam logic [5:0] F_SRA   = 6'd3;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
   localparam logic [5:0] F_MULT  = 6'd24;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIV   = 6'd26;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_SLT   = 6'd42;

   // S_HOLD counts out a divide-by-zero with a preloaded result so its timing
   // matches every other divide.
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_HOLD} state_t;

   state_t           state_q;
   logic             busy_q, done_q;
   logic [CW-1:0]    cnt_q;
   logic             qneg_q;    // negate product / quotient at completion
   logic             rneg_q;    // negate remainder at completion
   logic [WIDTH-1:0] b_q;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_hi_q;  // partial product high / partial remainder
   logic [WIDTH-1:0] acc_lo_q;  // multiplier bits / dividend-quotient bits
   logic [WIDTH-1:0] hi_q, lo_q;

   // ---------------------------------------------------------------- ALU
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] slt_res;
   logic [WIDTH-1:0] shift_res;

   assign slt_res = {{(WIDTH-1){1'b0}}, $signed(dataA) < $signed(dataB)};

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the case statements can leave it unassigned (no latch).
   always_comb begin
      alu_res = '0;
      case (ALUOp)
         2'b00: alu_res = dataA + dataB;
         2'b01: alu_res = dataA - dataB;
         2'b11: alu_res = slt_res;
         default: begin
            case (funct)
               F_ADD: alu_res = dataA + dataB;
               F_SUB: alu_res = dataA - dataB;
               F_AND: alu_res = dataA & dataB;
               F_OR:  alu_res = dataA | dataB;
               F_SLT: alu_res = slt_res;
               default: alu_res = '0;
            endcase
         end
      endcase
   end

   always_comb begin
      shift_res = '0;
      case (funct)
         F_SLL:   shift_res = dataB << shamt;
         F_SRL:   shift_res = dataB >> shamt;
         F_SRA:   shift_res = $signed(dataB) >>> shamt;
         default: shift_res = '0;
      endcase
   end

   always_comb begin
      Output = '0;
      if (ALUOp != 2'b10) begin
         Output = alu_res;
      end else begin
         case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: Output = alu_res;
            F_SLL, F_SRL, F_SRA:              Output = shift_res;
            F_MFHI:                           Output = hi_q;
            F_MFLO:                           Output = lo_q;
            default:                          Output = '0;
         endcase
      end
   end

   // Shifter and HI/LO paths feed Output only; zero tracks the ALU alone.
   assign zero = (alu_res == '0);

   // -------------------------------------------------------- issue decode
   logic is_rtype, is_mdu, is_hilo_user, accept;

   assign is_rtype     = (ALUOp == 2'b10);
   assign is_mdu       = funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
   assign is_hilo_user = is_mdu || (funct == F_MFHI) || (funct == F_MFLO);
   assign accept       = start && !busy_q && is_rtype && is_mdu;
   assign stall        = busy_q && start && is_rtype && is_hilo_user;

   // Operand magnitudes; MULT/DIV are the even codes of the pair.
   logic             signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign signed_op = !funct[0];
   assign a_neg     = signed_op && dataA[WIDTH-1];
   assign b_neg     = signed_op && dataB[WIDTH-1];
   assign a_mag     = a_neg ? -dataA : dataA;
   assign b_mag     = b_neg ? -dataB : dataB;

   // ------------------------------------------------------ iteration step
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic               div_borrow;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fin_hi, fin_lo;

   assign mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
   assign div_shift  = {acc_hi_q, acc_lo_q[WIDTH-1]};
   // One guard bit above the shifted remainder makes the top bit a clean
   // borrow flag for the trial subtraction.
   assign div_diff   = {1'b0, div_shift} - {2'b00, b_q};
   assign div_borrow = div_diff[WIDTH+1];

   always_comb begin
      step_hi = acc_hi_q;
      step_lo = acc_lo_q;
      case (state_q)
         S_MUL: begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
         end
         S_DIV: begin
            // Restore on borrow: keep the shifted remainder unchanged.
            step_hi = div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], !div_borrow};
         end
         default: ;
      endcase
   end

   assign prod = qneg_q ? -{step_hi, step_lo} : {step_hi, step_lo};

   always_comb begin
      fin_hi = step_hi;
      fin_lo = step_lo;
      case (state_q)
         S_MUL: begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
         end
         S_DIV: begin
            fin_hi = rneg_q ? -step_hi : step_hi;
            fin_lo = qneg_q ? -step_lo : step_lo;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------- sequencer
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  busy_q <= 1'b1;
                  cnt_q  <= CW'(WIDTH);
                  qneg_q <= a_neg ^ b_neg;
                  rneg_q <= a_neg;
                  if (!funct[1]) begin
                     state_q  <= S_MUL;
                     b_q      <= a_mag;
                     acc_hi_q <= '0;
                     acc_lo_q <= b_mag;
                  end else if (dataB == '0) begin
                     state_q  <= S_HOLD;
                     b_q      <= '0;
                     acc_hi_q <= dataA;
                     acc_lo_q <= '1;
                  end else begin
                     state_q  <= S_DIV;
                     b_q      <= b_mag;
                     acc_hi_q <= '0;
                     acc_lo_q <= a_mag;
                  end
               end
            end
            default: begin
               acc_hi_q <= step_hi;
               acc_lo_q <= step_lo;
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  hi_q    <= fin_hi;
                  lo_q    <= fin_lo;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_multicycle_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_exec_unit
//
// Directed bench for multicycle_exec_unit. A WIDTH=32 instance is compared on
// every cycle against an arithmetic reference (HI/LO results computed with
// native 64-bit math, a countdown for the busy window); literal checks pin the
// reference on the documented cases. A second WIDTH=16 instance covers the
// narrow configuration.
// -----------------------------------------------------------------------------
module tb_multicycle_exec_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // WIDTH=32 instance
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic        start;
   logic [31:0] a, b;
   logic [4:0]  sh;
   logic [31:0] out;
   logic        zero, busy, done, stall;

   // WIDTH=16 instance
   logic [1:0]  vop;
   logic [5:0]  vf;
   logic        vst;
   logic [15:0] va, vb;
   logic [3:0]  vs;
   logic [15:0] vout;
   logic        vzero, vbusy, vdone, vstall;

   multicycle_exec_unit #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(rst_n), .ALUOp(aluop), .funct(funct), .start(start),
      .dataA(a), .dataB(b), .shamt(sh), .Output(out), .zero(zero),
      .busy(busy), .done(done), .stall(stall)
   );

   multicycle_exec_unit #(.WIDTH(16)) u_dut16 (
      .clk(clk), .reset(rst_n), .ALUOp(vop), .funct(vf), .start(vst),
      .dataA(va), .dataB(vb), .shamt(vs), .Output(vout), .zero(vzero),
      .busy(vbusy), .done(vdone), .stall(vstall)
   );

   int n_total = 0;
   int n_bad   = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------ reference model
   function automatic logic [63:0] ref_mdu(input logic [5:0] f, input logic [31:0] x,
                                           input logic [31:0] y);
      longint sx, sy;
      logic [63:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = '0;
      case (f)
         6'd24: r = 64'(sx * sy);
         6'd25: r = {32'b0, x} * {32'b0, y};
         6'd26: r = (y == 0) ? {x, 32'hFFFFFFFF} : {32'(sx % sy), 32'(sx / sy)};
         6'd27: r = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] ref_out(input logic [1:0] op, input logic [5:0] f,
                                           input logic [31:0] x, input logic [31:0] y,
                                           input logic [4:0] s, input logic [31:0] hi,
                                           input logic [31:0] lo);
      logic [31:0] slt;
      slt = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      case (op)
         2'b00: return x + y;
         2'b01: return x - y;
         2'b11: return slt;
         default: begin
            case (f)
               6'd32: return x + y;
               6'd34: return x - y;
               6'd36: return x & y;
               6'd37: return x | y;
               6'd42: return slt;
               6'd0:  return y << s;
               6'd2:  return y >> s;
               6'd3:  return 32'($signed(y) >>> s);
               6'd16: return hi;
               6'd18: return lo;
               default: return 32'd0;
            endcase
         end
      endcase
   endfunction

   function automatic bit is_alu(input logic [1:0] op, input logic [5:0] f);
      return (op != 2'b10) || (f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42});
   endfunction

   logic        m_busy, m_done;
   int          m_left;
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_pend <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_hi   <= m_pend[63:32];
               m_lo   <= m_pend[31:0];
               m_busy <= 1'b0;
               m_done <= 1'b1;
            end
            m_left <= m_left - 1;
         end else if (start && aluop == 2'b10 && funct inside {6'd24, 6'd25, 6'd26, 6'd27}) begin
            m_pend <= ref_mdu(funct, a, b);
            m_busy <= 1'b1;
            m_left <= 32;
         end
      end
   end

   // Every-cycle comparison of the 32-bit instance against the reference.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_out", out, ref_out(aluop, funct, a, b, sh, m_hi, m_lo));
         check("cyc_busy", busy, m_busy);
         check("cyc_done", done, m_done);
         check("cyc_stall", stall, m_busy && start && aluop == 2'b10 &&
                                   (funct inside {6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27}));
         if (is_alu(aluop, funct))
            check("cyc_zero", zero, ref_out(aluop, funct, a, b, sh, m_hi, m_lo) == 32'd0);
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic put(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                      input logic [31:0] y, input logic [4:0] s, input logic st);
      aluop = op; funct = f; a = x; b = y; sh = s; start = st;
   endtask

   // Apply a vector just after an edge and return at the following negedge.
   task automatic step(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] s, input logic st);
      @(posedge clk); #1;
      put(op, f, x, y, s, st);
      @(negedge clk);
   endtask

   // Returns at the negedge of the done cycle (or after a bounded timeout).
   task automatic wait_done(input string name, output int busy_cycles);
      bit seen;
      seen = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) busy_cycles++;
      end
      check({name, "_done_seen"}, seen, 1'b1);
   endtask

   task automatic run_mdu(input string name, input logic [5:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
      int nb;
      @(posedge clk); #1;
      put(2'b10, f, x, y, 5'd0, 1'b1);
      @(posedge clk); #1;
      put(2'b00, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      wait_done(name, nb);
      check({name, "_busy_cycles"}, nb, 32);
      step(2'b10, 6'd18, 32'd0, 32'd0, 5'd0, 1'b1);
      check({name, "_lo"}, out, exp_lo);
      step(2'b10, 6'd16, 32'd0, 32'd0, 5'd0, 1'b1);
      check({name, "_hi"}, out, exp_hi);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int nb, ns;
      bit seen;
      rst_n = 1'b0;
      put(2'b00, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      vop = 2'b00; vf = 6'd0; vst = 1'b0; va = '0; vb = '0; vs = '0;

      // Reset state, with an MFHI presented while reset is held.
      repeat (2) @(posedge clk);
      #1;
      put(2'b10, 6'd16, 32'd0, 32'd0, 5'd0, 1'b1);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_hi", out, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      put(2'b00, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);

      // Combinational ALU.
      step(2'b00, 6'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1);
      check("add_out", out, 32'h80000000);
      check("add_zero", zero, 1'b0);
      step(2'b01, 6'd0, 32'd5, 32'd5, 5'd0, 1'b1);
      check("sub_out", out, 32'd0);
      check("sub_zero", zero, 1'b1);
      step(2'b11, 6'd0, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1);
      check("slt_out", out, 32'd1);
      step(2'b10, 6'd36, 32'h0000F0F0, 32'h0000FF00, 5'd0, 1'b1);
      check("and_out", out, 32'h0000F000);
      step(2'b10, 6'd37, 32'h0000F0F0, 32'h0000FF00, 5'd0, 1'b1);
      check("or_out", out, 32'h0000FFF0);
      step(2'b10, 6'd63, 32'h12345678, 32'h9ABCDEF0, 5'd7, 1'b1);
      check("unknown_out", out, 32'd0);

      // Shifter.
      step(2'b10, 6'd3, 32'd0, 32'h80000000, 5'd4, 1'b1);
      check("sra_out", out, 32'hF8000000);
      step(2'b10, 6'd2, 32'd0, 32'h80000000, 5'd4, 1'b1);
      check("srl_out", out, 32'h08000000);
      step(2'b10, 6'd0, 32'd0, 32'd1, 5'd31, 1'b1);
      check("sll_out", out, 32'h80000000);

      // MULT -3 x 7 followed by an MFLO held under stall.
      @(posedge clk); #1;
      put(2'b10, 6'd24, 32'hFFFFFFFD, 32'd7, 5'd0, 1'b1);
      @(posedge clk); #1;
      put(2'b10, 6'd18, 32'd0, 32'd0, 5'd0, 1'b1);
      nb = 0; ns = 0; seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            if (busy)  nb++;
            if (stall) ns++;
         end
      end
      check("mult_done_seen", seen, 1'b1);
      check("mult_busy_cycles", nb, 32);
      check("mult_stall_cycles", ns, 32);
      check("mult_busy_at_done", busy, 1'b0);
      check("mult_lo", out, 32'hFFFFFFEB);
      step(2'b10, 6'd16, 32'd0, 32'd0, 5'd0, 1'b1);
      check("mult_hi", out, 32'hFFFFFFFF);

      run_mdu("multu", 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_mdu("div_neg", 6'd26, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_mdu("divu_zero", 6'd27, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
      run_mdu("div_zero", 6'd26, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
      run_mdu("div_ovf", 6'd26, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
      run_mdu("divu_big", 6'd27, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999);

      // Back-to-back: a new op issued in the done cycle.
      @(posedge clk); #1;
      put(2'b10, 6'd25, 32'd3, 32'd5, 5'd0, 1'b1);
      @(posedge clk); #1;
      put(2'b00, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      wait_done("b2b_first", nb);
      put(2'b10, 6'd24, 32'd2, 32'hFFFFFFFC, 5'd0, 1'b1);
      @(posedge clk); #1;
      put(2'b00, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      check("b2b_busy", busy, 1'b1);
      wait_done("b2b_second", nb);
      check("b2b_busy_cycles", nb, 31);
      step(2'b10, 6'd18, 32'd0, 32'd0, 5'd0, 1'b0);
      check("b2b_lo", out, 32'hFFFFFFF8);
      step(2'b10, 6'd16, 32'd0, 32'd0, 5'd0, 1'b0);
      check("b2b_hi", out, 32'hFFFFFFFF);

      // Reset in the tenth cycle of a MULTU aborts it and clears HI/LO.
      @(posedge clk); #1;
      put(2'b10, 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b1);
      @(posedge clk); #1;
      put(2'b00, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      put(2'b10, 6'd16, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      check("abort_hi", out, 32'd0);
      step(2'b10, 6'd18, 32'd0, 32'd0, 5'd0, 1'b0);
      check("abort_lo", out, 32'd0);
      repeat (3) @(negedge clk);
      check("abort_no_done", done, 1'b0);

      // WIDTH=16: MULTU 0xFFFF x 2.
      @(posedge clk); #1;
      vop = 2'b10; vf = 6'd25; va = 16'hFFFF; vb = 16'd2; vst = 1'b1;
      @(posedge clk); #1;
      vop = 2'b00; vf = 6'd0; vst = 1'b0;
      nb = 0; seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (vdone) seen = 1'b1;
         else if (vbusy) nb++;
      end
      check("w16_done_seen", seen, 1'b1);
      check("w16_busy_cycles", nb, 16);
      @(posedge clk); #1;
      vop = 2'b10; vf = 6'd16;
      @(negedge clk);
      check("w16_hi", vout, 16'h0001);
      @(posedge clk); #1;
      vf = 6'd18;
      @(negedge clk);
      check("w16_lo", vout, 16'hFFFE);
      @(posedge clk); #1;
      vop = 2'b00; vf = 6'd0; va = 16'h7FFF; vb = 16'h0001;
      @(negedge clk);
      check("w16_add", vout, 16'h8000);
      check("w16_zero", vzero, 1'b0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_exec_unit.md
# multicycle_exec_unit

Parametrised execution unit for the pipelined CPU: combinational ALU and barrel shifter plus an iterative signed/unsigned multiplier and divider writing a HI/LO register pair. It sits in the EX stage in place of the single-width ALU/shifter/multiplier cluster. It raises a stall to the hazard logic while a multi-cycle operation is in flight.

## Interface

**Parameters**
- `WIDTH`, 32: datapath width; must be even and ≥ 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width.

**Ports**
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `ALUOp` in 2: 00 ADD, 01 SUB, 10 decode `funct`, 11 SLT.
- `funct` in 6: R-type function code.
- `start` in 1: instruction valid in EX this cycle.
- `dataA` in WIDTH: rs operand.
- `dataB` in WIDTH: rt operand.
- `shamt` in SHW: shift amount.
- `Output` out WIDTH: selected result.
- `zero` out 1: ALU result equals 0.
- `busy` out 1: multiply/divide in progress.
- `done` out 1: one-cycle pulse; HI/LO just updated.
- `stall` out 1: EX must hold this instruction.

## Operation

**Funct codes (ALUOp = 10)**
- AND 36, OR 37, ADD 32, SUB 34, SLT 42: ALU.
- SLL 0, SRL 2, SRA 3: shifter on `dataB` by `shamt`.
- MFHI 16, MFLO 18: read HI, LO.
- MULT 24, MULTU 25, DIV 26, DIVU 27: multi-cycle.
- Any other code: `Output` = 0.

**Combinational results**
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- SLT is a signed compare: result 1 or 0, zero-extended.
- `zero` reflects the ALU result only; shifter, HI and LO paths do not drive it.

**Multi-cycle ops**
- A multi-cycle op is accepted when `start`=1, `busy`=0, `ALUOp`=10 and `funct` ∈ {24..27}.
- On acceptance, the operands and op are captured and a cycle counter is loaded with WIDTH.
- Multiply is radix-2 shift-add on operand magnitudes. A signed result is negated when sign(A) ≠ sign(B). The 2·WIDTH-bit product goes to HI (upper half) and LO (lower half).
- Divide is restoring, on magnitudes. LO = quotient, HI = remainder.
  - Signed: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
  - Divide by zero: LO = all ones, HI = `dataA`, with no trap. Same result for signed and unsigned.
  - Signed most-negative ÷ −1: LO = most-negative, HI = 0.
- HI/LO change only at completion. Both reset to 0.

**stall**
- `stall` = `busy` & `start` & `ALUOp`=10 & `funct` ∈ {16, 18, 24..27}.
- All other instructions proceed while the unit is busy.
- A `start` that meets the acceptance conditions except `busy`=0 is not accepted. The instruction holds under `stall` and is accepted in the first cycle `busy`=0.

## Timing

- Combinational paths (ALU, shifter, MFHI/MFLO) are valid in the same cycle as their inputs.
- Acceptance happens at edge T0.
- `busy`=1 from T0 through edge T0+WIDTH.
- One iteration is performed per edge, T0+1 … T0+WIDTH.
- At edge T0+WIDTH:
  - HI/LO are written;
  - `busy` falls;
  - `done`=1 for exactly that cycle.
- MFHI/MFLO in the cycle after `done` return the new value. Latency from acceptance to readable HI/LO is WIDTH+1 cycles.
- Back-to-back: a new op may be accepted in the cycle `done`=1, since `busy`=0.
- Reset values: `busy`=0, `done`=0, `stall`=0, HI=LO=0, counter=0. `Output` and `zero` follow their inputs combinationally.
- Reset asserted mid-operation aborts it; HI/LO end at 0, not partial results.
- `start` deasserted while busy has no effect; the op completes.

## Test plan

1. WIDTH=32, ADD 0x7FFFFFFF + 1 → `Output`=0x80000000, `zero`=0. Then SUB 5−5 → 0, `zero`=1. Then SLT −1<1 → 1.
2. SRA 0x80000000 by 4 → 0xF8000000. SRL same → 0x08000000. SLL 1 by 31 → 0x80000000.
3. MULT −3 × 7, then MFLO held under `stall`:
   - `busy` high 32 cycles;
   - `done` pulses at T0+32;
   - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
4. MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
5. Divide cases:
   - DIV −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIVU 7 ÷ 0 → LO=0xFFFFFFFF, HI=7.
   - DIV 0x80000000 ÷ −1 → LO=0x80000000, HI=0.
6. Reset mid-op and WIDTH variation:
   - Pull `reset` low at cycle 10 of a MULTU → `busy`=0, HI=LO=0.
   - Re-run WIDTH=16: MULTU 0xFFFF × 2 → HI=0x0001, LO=0xFFFE, `busy` 16 cycles.
